// File: rtl/dac_seq_ctrl.sv
// DAC playback sequencer: plays FIFO beats for a programmed number of beats and repeats, with
// pre/gap/post zero padding, first/last-beat edge masking and an idle locking waveform.
module dac_seq_ctrl #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned SPB      = 16,
   parameter int unsigned CFG_W    = 32,
   localparam int unsigned DATA_W  = SAMPLE_W * SPB
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              trigger_in,
   input  logic              abort_in,
   input  logic [CFG_W-1:0]  cfg_cycles,
   input  logic [CFG_W-1:0]  cfg_repeats,
   input  logic [CFG_W-1:0]  cfg_pre,
   input  logic [CFG_W-1:0]  cfg_gap,
   input  logic [CFG_W-1:0]  cfg_post,
   input  logic [SPB-1:0]    cfg_mask,
   input  logic              cfg_mask_en,
   input  logic              cfg_lock_en,
   input  logic              cfg_loop_en,
   input  logic [DATA_W-1:0] locking_waveform,
   output logic              loopback_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic              trig_missed
);

   localparam logic [CFG_W-1:0] One = CFG_W'(1);

   typedef enum logic [2:0] {StIdle, StPre, StRun, StGap, StPost} state_e;

   state_e            state_q, state_d;
   logic [CFG_W-1:0]  cnt_q, cnt_d;
   logic [CFG_W-1:0]  rep_q, rep_d;
   logic [CFG_W-1:0]  cycles_q, cycles_d;
   logic [CFG_W-1:0]  repeats_q, repeats_d;
   logic [CFG_W-1:0]  pre_q, pre_d;
   logic [CFG_W-1:0]  gap_q, gap_d;
   logic [CFG_W-1:0]  post_q, post_d;
   logic [SPB-1:0]    mask_q, mask_d;
   logic              mask_en_q, mask_en_d;
   logic              loop_en_q, loop_en_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              done_q, done_d;
   logic              underrun_q, underrun_d;
   logic              trig_missed_q, trig_missed_d;

   logic              tick;
   logic              accept;
   logic              complete;
   logic              first_beat;
   logic              last_beat;
   logic [CFG_W-1:0]  rep_last;
   logic [DATA_W-1:0] masked;

   assign tick       = m_axis_tready;
   assign first_beat = (cnt_q == '0);
   assign last_beat  = (cnt_q == cycles_q - One);
   // A repeat count of zero behaves as a single repeat.
   assign rep_last   = (repeats_q == '0) ? '0 : repeats_q - One;

   // State and configuration register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         rep_q         <= '0;
         cycles_q      <= '0;
         repeats_q     <= '0;
         pre_q         <= '0;
         gap_q         <= '0;
         post_q        <= '0;
         mask_q        <= '0;
         mask_en_q     <= 1'b0;
         loop_en_q     <= 1'b0;
         out_q         <= '0;
         done_q        <= 1'b0;
         underrun_q    <= 1'b0;
         trig_missed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rep_q         <= rep_d;
         cycles_q      <= cycles_d;
         repeats_q     <= repeats_d;
         pre_q         <= pre_d;
         gap_q         <= gap_d;
         post_q        <= post_d;
         mask_q        <= mask_d;
         mask_en_q     <= mask_en_d;
         loop_en_q     <= loop_en_d;
         out_q         <= out_d;
         done_q        <= done_d;
         underrun_q    <= underrun_d;
         trig_missed_q <= trig_missed_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rep_d     = rep_q;
      cycles_d  = cycles_q;
      repeats_d = repeats_q;
      pre_d     = pre_q;
      gap_d     = gap_q;
      post_d    = post_q;
      mask_d    = mask_q;
      mask_en_d = mask_en_q;
      loop_en_d = loop_en_q;
      accept    = 1'b0;
      complete  = 1'b0;
      if (abort_in) begin
         state_d = StIdle;
         cnt_d   = '0;
         rep_d   = '0;
      end else if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (trigger_in) begin
                  accept    = 1'b1;
                  cycles_d  = cfg_cycles;
                  repeats_d = cfg_repeats;
                  pre_d     = cfg_pre;
                  gap_d     = cfg_gap;
                  post_d    = cfg_post;
                  mask_d    = cfg_mask;
                  mask_en_d = cfg_mask_en;
                  loop_en_d = cfg_loop_en;
                  cnt_d     = '0;
                  rep_d     = '0;
                  if (cfg_pre != '0)         state_d = StPre;
                  else if (cfg_cycles != '0) state_d = StRun;
                  else if (cfg_post != '0)   state_d = StPost;
                  else                       complete = 1'b1;
               end
            end
            StPre: begin
               if (cnt_q == pre_q - One) begin
                  cnt_d = '0;
                  if (cycles_q != '0)    state_d = StRun;
                  else if (post_q != '0) state_d = StPost;
                  else begin
                     state_d  = StIdle;
                     complete = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + One;
               end
            end
            StRun: begin
               if (last_beat) begin
                  cnt_d = '0;
                  if (rep_q == rep_last) begin
                     rep_d = '0;
                     if (post_q != '0) state_d = StPost;
                     else begin
                        state_d  = StIdle;
                        complete = 1'b1;
                     end
                  end else begin
                     rep_d   = rep_q + One;
                     state_d = (gap_q != '0) ? StGap : StRun;
                  end
               end else begin
                  cnt_d = cnt_q + One;
               end
            end
            StGap: begin
               if (cnt_q == gap_q - One) begin
                  cnt_d   = '0;
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + One;
               end
            end
            StPost: begin
               if (cnt_q == post_q - One) begin
                  cnt_d    = '0;
                  state_d  = StIdle;
                  complete = 1'b1;
               end else begin
                  cnt_d = cnt_q + One;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Edge masking of the incoming beat
   always_comb begin
      masked = s_axis_tdata;
      if (mask_en_q) begin
         for (int i = 0; i < SPB; i++) begin
            if (first_beat) begin
               if (!mask_q[i]) masked[i*SAMPLE_W +: SAMPLE_W] = '0;
            end else if (last_beat) begin
               if (mask_q[i]) masked[i*SAMPLE_W +: SAMPLE_W] = '0;
            end
         end
      end
   end

   // Output logic
   always_comb begin
      s_axis_tready = (state_q == StRun) && tick && !abort_in;
      out_d         = out_q;
      done_d        = complete;
      underrun_d    = accept ? 1'b0 : underrun_q;
      trig_missed_d = accept ? 1'b0 : trig_missed_q;
      // On abort the register holds; the idle value loads on the first tick back in IDLE.
      if (tick && !abort_in) begin
         unique case (state_q)
            StIdle:  out_d = cfg_lock_en ? locking_waveform : '0;
            StRun:   out_d = s_axis_tvalid ? masked : '0;
            default: out_d = '0;
         endcase
         if (state_q == StRun && !s_axis_tvalid) underrun_d = 1'b1;
         if (state_q != StIdle && trigger_in)    trig_missed_d = 1'b1;
      end
   end

   assign m_axis_tdata   = out_q;
   assign m_axis_tvalid  = 1'b1;
   assign loopback_valid = loop_en_q && s_axis_tready && s_axis_tvalid;
   assign busy           = (state_q != StIdle);
   assign done           = done_q;
   assign underrun       = underrun_q;
   assign trig_missed    = trig_missed_q;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Directed bench for dac_seq_ctrl: records the output register after every tick and compares
// against hand-built beat sequences, plus pop/loopback/done counts and flag behaviour.
module tb_dac_seq_ctrl;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned SPB      = 16;
   localparam int unsigned CFG_W    = 32;
   localparam int unsigned DATA_W   = SAMPLE_W * SPB;

   localparam logic [DATA_W-1:0] LoHalf = {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};
   localparam logic [DATA_W-1:0] HiHalf = {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}};
   localparam logic [DATA_W-1:0] Lock   = {SPB{16'hA5C3}};
   localparam logic [DATA_W-1:0] Zero   = '0;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              trigger_in;
   logic              abort_in;
   logic [CFG_W-1:0]  cfg_cycles, cfg_repeats, cfg_pre, cfg_gap, cfg_post;
   logic [SPB-1:0]    cfg_mask;
   logic              cfg_mask_en, cfg_lock_en, cfg_loop_en;
   logic              loopback_valid, busy, done, underrun, trig_missed;

   int checks = 0;
   int errors = 0;

   int pops = 0, lb_cnt = 0, run_ticks = 0, done_cnt = 0, rd_ptr = 0;
   int pop_base, lb_base, run_base, done_base, rd_base;
   logic hole_en = 1'b0;
   logic cap_en  = 1'b0;
   logic tick_s;
   logic [DATA_W-1:0] cap_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got;

   dac_seq_ctrl #(.SAMPLE_W(SAMPLE_W), .SPB(SPB), .CFG_W(CFG_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .trigger_in       (trigger_in),
      .abort_in         (abort_in),
      .cfg_cycles       (cfg_cycles),
      .cfg_repeats      (cfg_repeats),
      .cfg_pre          (cfg_pre),
      .cfg_gap          (cfg_gap),
      .cfg_post         (cfg_post),
      .cfg_mask         (cfg_mask),
      .cfg_mask_en      (cfg_mask_en),
      .cfg_lock_en      (cfg_lock_en),
      .cfg_loop_en      (cfg_loop_en),
      .locking_waveform (Lock),
      .loopback_valid   (loopback_valid),
      .busy             (busy),
      .done             (done),
      .underrun         (underrun),
      .trig_missed      (trig_missed)
   );

   always #5 clk = ~clk;

   // FIFO contents: sample i of beat k is {k+1, i+1}
   function automatic logic [DATA_W-1:0] make_beat(input int k);
      logic [DATA_W-1:0] b;
      for (int i = 0; i < SPB; i++) b[i*SAMPLE_W +: SAMPLE_W] = 16'((k + 1) * 256 + i + 1);
      return b;
   endfunction

   function automatic logic [DATA_W-1:0] beat(input int k);
      return make_beat(rd_base + k);
   endfunction

   assign s_axis_tdata  = make_beat(rd_ptr);
   assign s_axis_tvalid = !(hole_en && (run_ticks - run_base) == 2);

   always @(posedge clk) begin
      if (s_axis_tready && s_axis_tvalid) begin
         pops   <= pops + 1;
         rd_ptr <= rd_ptr + 1;
      end
      if (loopback_valid) lb_cnt <= lb_cnt + 1;
      if (s_axis_tready) run_ticks <= run_ticks + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   // Record the output register just after every tick
   always @(posedge clk) begin
      tick_s <= m_axis_tready;
      #1;
      if (cap_en && tick_s) cap_q.push_back(m_axis_tdata);
   end

   task automatic set_cfg(input int cyc, input int reps, input int pre, input int gap,
                          input int post, input logic [SPB-1:0] mask, input logic men,
                          input logic len);
      cfg_cycles  = CFG_W'(cyc);
      cfg_repeats = CFG_W'(reps);
      cfg_pre     = CFG_W'(pre);
      cfg_gap     = CFG_W'(gap);
      cfg_post    = CFG_W'(post);
      cfg_mask    = mask;
      cfg_mask_en = men;
      cfg_loop_en = len;
   endtask

   // Raise trigger_in until a tick samples it; returns on the following negedge
   task automatic pulse_trigger();
      int n = 0;
      @(negedge clk);
      pop_base  = pops;
      lb_base   = lb_cnt;
      run_base  = run_ticks;
      done_base = done_cnt;
      rd_base   = rd_ptr;
      cap_q.delete();
      cap_en     = 1'b1;
      trigger_in = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!tick_s && n < 20);
      trigger_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      trigger_in = 1'b0;
      abort_in = 1'b0;
      m_axis_tready = 1'b1;
      cfg_lock_en = 1'b0;
      set_cfg(0, 0, 0, 0, 0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (m_axis_tdata !== Zero || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 ||
          loopback_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 ||
          trig_missed !== 1'b0) begin
         errors++;
         $display("FAIL reset: tdata=%h tvalid=%b s_tready=%b lb=%b busy=%b done=%b ur=%b tm=%b, required tdata 0 tvalid 1 rest 0",
                  m_axis_tdata, m_axis_tvalid, s_axis_tready, loopback_valid, busy, done,
                  underrun, trig_missed);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_masked_burst();
      set_cfg(4, 1, 2, 0, 3, 16'h00FF, 1'b1, 1'b0);
      pulse_trigger();
      wait_idle();
      exp_q = {};
      exp_q.push_back(Zero);
      exp_q.push_back(Zero);
      exp_q.push_back(Zero);
      exp_q.push_back(beat(0) & LoHalf);
      exp_q.push_back(beat(1));
      exp_q.push_back(beat(2));
      exp_q.push_back(beat(3) & HiHalf);
      repeat (4) exp_q.push_back(Zero);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         got = (k < cap_q.size()) ? cap_q[k] : 'x;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL masked_burst tick %0d: got %h required %h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (pops - pop_base != 4) begin
         errors++;
         $display("FAIL masked_burst pops: got %0d required 4", pops - pop_base);
      end
      checks++;
      if (done_cnt - done_base != 1) begin
         errors++;
         $display("FAIL masked_burst done pulses: got %0d required 1", done_cnt - done_base);
      end
      checks++;
      if (lb_cnt - lb_base != 0) begin
         errors++;
         $display("FAIL masked_burst loopback: got %0d required 0", lb_cnt - lb_base);
      end
   endtask

   task automatic test_repeats();
      set_cfg(3, 3, 0, 2, 0, '0, 1'b0, 1'b1);
      pulse_trigger();
      wait_idle();
      exp_q = {};
      exp_q.push_back(Zero);
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < 3; b++) exp_q.push_back(beat(r * 3 + b));
         if (r < 2) begin
            exp_q.push_back(Zero);
            exp_q.push_back(Zero);
         end
      end
      exp_q.push_back(Zero);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         got = (k < cap_q.size()) ? cap_q[k] : 'x;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL repeats tick %0d: got %h required %h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (pops - pop_base != 9 || lb_cnt - lb_base != 9) begin
         errors++;
         $display("FAIL repeats pops/loopback: got %0d/%0d required 9/9", pops - pop_base,
                  lb_cnt - lb_base);
      end
      checks++;
      if (done_cnt - done_base != 1) begin
         errors++;
         $display("FAIL repeats done pulses: got %0d required 1", done_cnt - done_base);
      end
   endtask

   task automatic test_stall();
      set_cfg(8, 1, 0, 0, 0, '0, 1'b0, 1'b0);
      pulse_trigger();
      for (int n = 0; n < 40; n++) begin
         m_axis_tready = ~m_axis_tready;
         @(negedge clk);
      end
      m_axis_tready = 1'b1;
      wait_idle();
      exp_q = {};
      exp_q.push_back(Zero);
      for (int b = 0; b < 8; b++) exp_q.push_back(beat(b));
      exp_q.push_back(Zero);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         got = (k < cap_q.size()) ? cap_q[k] : 'x;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL stall tick %0d: got %h required %h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (pops - pop_base != 8) begin
         errors++;
         $display("FAIL stall pops: got %0d required 8", pops - pop_base);
      end
   endtask

   task automatic test_underrun();
      set_cfg(5, 1, 0, 0, 0, '0, 1'b0, 1'b0);
      hole_en = 1'b1;
      pulse_trigger();
      wait_idle();
      hole_en = 1'b0;
      exp_q = {};
      exp_q.push_back(Zero);
      exp_q.push_back(beat(0));
      exp_q.push_back(beat(1));
      exp_q.push_back(Zero);
      exp_q.push_back(beat(2));
      exp_q.push_back(beat(3));
      exp_q.push_back(Zero);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         got = (k < cap_q.size()) ? cap_q[k] : 'x;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL underrun tick %0d: got %h required %h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun flag: got %b required 1", underrun);
      end
      checks++;
      if (run_ticks - run_base != 5 || pops - pop_base != 4) begin
         errors++;
         $display("FAIL underrun counts: run ticks %0d pops %0d, required 5 and 4",
                  run_ticks - run_base, pops - pop_base);
      end
   endtask

   task automatic test_trig_abort();
      cfg_lock_en = 1'b1;
      set_cfg(6, 1, 0, 0, 0, '0, 1'b0, 1'b0);
      pulse_trigger();
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL sticky clear on trigger: underrun %b required 0", underrun);
      end
      trigger_in = 1'b1;
      @(negedge clk);
      trigger_in = 1'b0;
      checks++;
      if (trig_missed !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL trig_missed: got tm=%b busy=%b required 1/1", trig_missed, busy);
      end
      @(negedge clk);
      abort_in = 1'b1;
      #1;
      checks++;
      if (s_axis_tready !== 1'b0) begin
         errors++;
         $display("FAIL abort s_tready: got %b required 0", s_axis_tready);
      end
      @(negedge clk);
      abort_in = 1'b0;
      checks++;
      if (busy !== 1'b0 || pops - pop_base != 2) begin
         errors++;
         $display("FAIL abort idle: busy %b pops %0d required 0 and 2", busy, pops - pop_base);
      end
      @(negedge clk);
      checks++;
      if (m_axis_tdata !== Lock) begin
         errors++;
         $display("FAIL abort locking: got %h required %h", m_axis_tdata, Lock);
      end
      checks++;
      if (done_cnt != done_base) begin
         errors++;
         $display("FAIL abort done: got %0d pulses required 0", done_cnt - done_base);
      end
      cfg_lock_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_cycles();
      set_cfg(0, 1, 0, 0, 0, '0, 1'b0, 1'b0);
      pulse_trigger();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_cycles done: got done=%b busy=%b required 1/0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || pops != pop_base) begin
         errors++;
         $display("FAIL zero_cycles after: done=%b pops=%0d required 0 and 0", done,
                  pops - pop_base);
      end
   endtask

   task automatic test_single_beat();
      set_cfg(1, 1, 0, 0, 0, 16'h00FF, 1'b1, 1'b0);
      pulse_trigger();
      wait_idle();
      checks++;
      got = (cap_q.size() > 1) ? cap_q[1] : 'x;
      if (got !== (beat(0) & LoHalf)) begin
         errors++;
         $display("FAIL single_beat data: got %h required %h", got, beat(0) & LoHalf);
      end
      checks++;
      if (pops - pop_base != 1) begin
         errors++;
         $display("FAIL single_beat pops: got %0d required 1", pops - pop_base);
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(20, 1, 0, 0, 0, '0, 1'b0, 1'b0);
      pulse_trigger();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || m_axis_tdata !== Zero || s_axis_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b tdata=%h s_tready=%b required 0/0/0", busy,
                  m_axis_tdata, s_axis_tready);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_masked_burst();
      test_repeats();
      test_stall();
      test_underrun();
      test_trig_abort();
      test_zero_cycles();
      test_single_beat();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
